// File: rtl/bfp_block_align_if.sv
`default_nettype none
// ============================================================================
// Module   : bfp_block_align_if
// Brief    : Input/output beat streams of the block-floating-point aligner.
// Revision : 1.0 - initial release
// ============================================================================
interface bfp_block_align_if #(
    parameter int P    = 4,
    parameter int BIT  = 32,
    parameter int FPM  = 23,
    parameter int BFPM = 4
);
    localparam int c_exp_w = BIT - FPM - 1;

    logic                   in_valid;
    logic                   in_ready;
    logic [P-1:0][BIT-1:0]  in_data;
    logic                   rnd_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [P-1:0][BFPM:0]   out_mants;
    logic [P-1:0]           out_signs;
    logic [c_exp_w-1:0]     out_exp;
    logic                   out_last;

    modport master (
        output in_valid, in_data, rnd_mode, out_ready,
        input  in_ready, out_valid, out_mants, out_signs, out_exp, out_last
    );

    modport slave (
        input  in_valid, in_data, rnd_mode, out_ready,
        output in_ready, out_valid, out_mants, out_signs, out_exp, out_last
    );
endinterface
`default_nettype wire

// File: rtl/bfp_block_align.sv
`default_nettype none
// ============================================================================
// Module   : bfp_block_align
// Brief    : Buffers one V-element FP block, finds its max exponent, then
//            drains P-lane beats of shifted BFP mantissas with backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module bfp_block_align #(
    parameter int V    = 16,
    parameter int P    = 4,
    parameter int BIT  = 32,
    parameter int FPM  = 23,
    parameter int BFPM = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    bfp_block_align_if.slave   bus
);
    localparam int c_exp_w   = BIT - FPM - 1;
    localparam int c_beats   = V / P;
    localparam int c_cnt_w   = (c_beats > 1) ? $clog2(c_beats) : 1;
    localparam int c_keep_w  = 1 + c_exp_w + BFPM + 1;
    localparam int c_drop_w  = BIT - c_keep_w;
    localparam int c_win_w   = BFPM + 2;
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(c_beats - 1);

    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t                        r_state;
    logic [c_cnt_w-1:0]            r_wr;
    logic [c_cnt_w-1:0]            r_rd;
    logic [c_exp_w-1:0]            r_max_exp;
    logic                          r_rnd;
    // Only sign, exponent and the mantissa bits that reach the output are kept.
    logic [P-1:0][c_keep_w-1:0]    r_buf [c_beats];

    logic [P-1:0][c_keep_w-1:0]    w_in_keep;
    logic [c_exp_w-1:0]            w_beat_max;
    logic                          w_unused_lsbs;
    logic [P-1:0][c_keep_w-1:0]    w_rd_beat;
    logic [P-1:0][BFPM:0]          w_mant;
    logic [P-1:0]                  w_sign;

    always_comb begin
        w_beat_max    = '0;
        w_unused_lsbs = 1'b0;
        w_in_keep     = '0;
        for (int l = 0; l < P; l++) begin
            w_in_keep[l]  = bus.in_data[l][BIT-1 -: c_keep_w];
            w_unused_lsbs = w_unused_lsbs ^ (^bus.in_data[l][c_drop_w-1:0]);
            if (bus.in_data[l][BIT-2 -: c_exp_w] > w_beat_max)
                w_beat_max = bus.in_data[l][BIT-2 -: c_exp_w];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FILL;
            r_wr      <= '0;
            r_rd      <= '0;
            r_max_exp <= '0;
            r_rnd     <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (bus.in_valid) begin
                        r_buf[r_wr] <= w_in_keep;
                        // First beat restarts the running maximum.
                        if (r_wr == '0 || w_beat_max > r_max_exp)
                            r_max_exp <= w_beat_max;
                        if (r_wr == '0)
                            r_rnd <= bus.rnd_mode;
                        if (r_wr == c_last_beat) begin
                            r_wr    <= '0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_wr <= r_wr + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.out_ready) begin
                        if (r_rd == c_last_beat) begin
                            r_rd    <= '0;
                            r_state <= S_FILL;
                        end else begin
                            r_rd <= r_rd + 1'b1;
                        end
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign w_rd_beat = r_buf[r_rd];

    for (genvar l = 0; l < P; l++) begin : g_lane
        logic [c_exp_w-1:0] w_e;
        logic [c_exp_w-1:0] w_d;
        logic [c_win_w-1:0] w_win;
        logic [c_win_w-1:0] w_shift;
        logic [BFPM:0]      w_trunc;

        assign w_e     = w_rd_beat[l][c_keep_w-2 -: c_exp_w];
        assign w_d     = r_max_exp - w_e;
        assign w_win   = {1'b1, w_rd_beat[l][BFPM:0]};
        assign w_shift = (w_d > c_exp_w'(BFPM + 1)) ? '0 : (w_win >> w_d);
        assign w_trunc = w_shift[c_win_w-1:1];
        // Round-half-up saturates rather than wrapping to zero.
        assign w_mant[l] = (w_e == '0) ? '0 :
                           (r_rnd && w_shift[0] && !(&w_trunc)) ?
                               w_trunc + {{BFPM{1'b0}}, 1'b1} : w_trunc;
        assign w_sign[l] = w_rd_beat[l][c_keep_w-1];
    end

    always_comb begin
        bus.in_ready  = (r_state == S_FILL);
        bus.out_valid = (r_state == S_DRAIN);
        bus.out_last  = 1'b0;
        bus.out_mants = '0;
        bus.out_signs = '0;
        bus.out_exp   = '0;
        if (r_state == S_DRAIN) begin
            bus.out_last  = (r_rd == c_last_beat);
            bus.out_mants = w_mant;
            bus.out_signs = w_sign;
            bus.out_exp   = r_max_exp;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_bfp_block_align.sv
`default_nettype none
// ============================================================================
// Module   : tb_bfp_block_align
// Brief    : Directed self-checking bench for bfp_block_align (P=4, V=16, FP32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bfp_block_align;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_assert = 0;
    int   n_fail = 0;

    logic [31:0]      blk   [16];
    logic [3:0][4:0]  exp_m [4];
    logic [3:0]       exp_s [4];
    logic [7:0]       exp_e;

    bfp_block_align_if #(.P(4), .BIT(32), .FPM(23), .BFPM(4)) bus ();

    bfp_block_align #(.V(16), .P(4), .BIT(32), .FPM(23), .BFPM(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic fill_block(input logic [31:0] w);
        for (int i = 0; i < 16; i++) blk[i] = w;
    endtask

    task automatic fill_expect(input logic [4:0] m, input logic [7:0] e);
        for (int b = 0; b < 4; b++) begin
            exp_m[b] = {4{m}};
            exp_s[b] = 4'b0000;
        end
        exp_e = e;
    endtask

    // Beats are fed with optional idle gaps; rnd_mode is inverted after beat 0.
    task automatic send_block(input logic rnd, input int nbeats, input int gap);
        for (int b = 0; b < nbeats; b++) begin
            bus.in_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
            n_assert++;
            if (bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL in_ready_fill beat %0d: got %b want 1", b, bus.in_ready);
            end
            bus.in_valid = 1'b1;
            bus.rnd_mode = (b == 0) ? rnd : ~rnd;
            for (int l = 0; l < 4; l++) bus.in_data[l] = blk[b*4 + l];
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic drain_block(input string tag, input int stall_beat, input int stall_cycles);
        bus.out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            n_assert++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s handshake beat %0d: valid=%b ready=%b want 1/0", tag, b, bus.out_valid, bus.in_ready);
            end
            n_assert++;
            if (bus.out_mants !== exp_m[b]) begin
                n_fail++;
                $display("FAIL %s mants beat %0d: got %h want %h", tag, b, bus.out_mants, exp_m[b]);
            end
            n_assert++;
            if (bus.out_signs !== exp_s[b] || bus.out_exp !== exp_e) begin
                n_fail++;
                $display("FAIL %s signs/exp beat %0d: got %b/%0d want %b/%0d", tag, b, bus.out_signs, bus.out_exp, exp_s[b], exp_e);
            end
            n_assert++;
            if (bus.out_last !== (b == 3)) begin
                n_fail++;
                $display("FAIL %s last beat %0d: got %b want %b", tag, b, bus.out_last, (b == 3));
            end
            if (b == stall_beat) begin
                bus.out_ready = 1'b0;
                repeat (stall_cycles) begin
                    @(posedge clk); #1;
                    n_assert++;
                    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                        bus.out_mants !== exp_m[b] || bus.out_last !== (b == 3)) begin
                        n_fail++;
                        $display("FAIL %s stall beat %0d: valid=%b ready=%b mants=%h last=%b want 1/0/%h/%b",
                                 tag, b, bus.out_valid, bus.in_ready, bus.out_mants, bus.out_last, exp_m[b], (b == 3));
                    end
                end
                bus.out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        n_assert++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s back_to_fill: valid=%b ready=%b want 0/1", tag, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic prep_case2();
        fill_block(32'h3F80_0000);
        blk[0] = 32'h4080_0000;
        fill_expect(5'b00100, 8'd129);
        exp_m[0][0] = 5'b10000;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_assert++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready=%b valid=%b last=%b want 1/0/0", bus.in_ready, bus.out_valid, bus.out_last);
        end
        n_assert++;
        if (bus.out_mants !== 20'h0 || bus.out_signs !== 4'h0 || bus.out_exp !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_data: mants=%h signs=%h exp=%h want 0/0/0", bus.out_mants, bus.out_signs, bus.out_exp);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unity();
        fill_block(32'h3F80_0000);
        fill_expect(5'b10000, 8'd127);
        send_block(1'b0, 4, 0);
        drain_block("unity", -1, 0);
    endtask

    task automatic test_max_lane();
        prep_case2();
        send_block(1'b0, 4, 0);
        drain_block("max_lane", -1, 0);
    endtask

    task automatic test_round();
        fill_block(32'h3FFC_0000);
        blk[0] = 32'h4100_0000;
        fill_expect(5'b00011, 8'd130);
        exp_m[0][0] = 5'b10000;
        send_block(1'b0, 4, 0);
        drain_block("round_trunc", -1, 0);

        fill_expect(5'b00100, 8'd130);
        exp_m[0][0] = 5'b10000;
        send_block(1'b1, 4, 0);
        drain_block("round_near", -1, 0);

        fill_block(32'h3FFC_0000);
        fill_expect(5'b11111, 8'd127);
        send_block(1'b1, 4, 0);
        drain_block("round_sat", -1, 0);
    endtask

    task automatic test_zero_sign();
        fill_block(32'h3F80_0000);
        blk[0] = 32'h0000_0000;
        blk[1] = 32'h8000_0000;
        blk[2] = 32'h3200_0000;
        blk[3] = 32'hB200_0000;
        fill_expect(5'b10000, 8'd127);
        exp_m[0] = '0;
        exp_s[0] = 4'b1010;
        send_block(1'b1, 4, 0);
        drain_block("zero_sign", -1, 0);
    endtask

    task automatic test_backpressure();
        prep_case2();
        send_block(1'b0, 4, 2);
        drain_block("backpressure", 1, 5);
    endtask

    task automatic test_reset_drain();
        prep_case2();
        send_block(1'b0, 4, 0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        n_assert++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_exp !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_drain: valid=%b ready=%b exp=%0d want 0/1/0", bus.out_valid, bus.in_ready, bus.out_exp);
        end
        send_block(1'b0, 4, 0);
        drain_block("after_reset_drain", -1, 0);
    endtask

    task automatic test_reset_fill();
        fill_block(32'h3F80_0000);
        blk[0] = 32'h4300_0000;
        send_block(1'b0, 2, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        prep_case2();
        send_block(1'b0, 4, 0);
        drain_block("after_reset_fill", -1, 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.rnd_mode  = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_unity();
        test_max_lane();
        test_round();
        test_zero_sign();
        test_backpressure();
        test_reset_drain();
        test_reset_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
